// File: rtl/boot_chain_verify_seq.sv
`default_nettype none
// ============================================================================
//  Module      : boot_chain_verify_seq
//  Description : Sequences a multi-stage secure boot chain over one shared
//                crypto verify engine. Each stage gets bounded retries and a
//                per-attempt timeout. A sticky release bit is set for each
//                verified stage. Tamper revokes every release and locks the
//                block in FAIL until reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module boot_chain_verify_seq #(
    parameter int NUM_STAGES    = 4,
    parameter int STAGE_TIMEOUT = 1024,
    parameter int MAX_RETRY     = 2,
    parameter int CNT_W         = 16,
    localparam int IW           = $clog2(NUM_STAGES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  boot_req,
    input  logic                  tamper,
    output logic                  crypto_start,
    output logic [IW-1:0]         crypto_img_idx,
    input  logic                  crypto_done,
    input  logic                  crypto_sig_ok,
    output logic [NUM_STAGES-1:0] stage_release,
    output logic                  chain_pass,
    output logic                  chain_fail,
    output logic [IW-1:0]         fail_stage,
    output logic                  busy
);

    localparam int c_RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [IW-1:0]    c_LAST_STAGE = IW'(NUM_STAGES - 1);
    localparam logic [CNT_W-1:0] c_TMO_LAST   = CNT_W'(STAGE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_TIMER_MAX  = {CNT_W{1'b1}};
    localparam logic [c_RW-1:0]  c_MAX_RETRY  = c_RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_PASS  = 3'd3,
        S_FAIL  = 3'd4
    } state_t;

    state_t            r_state;
    logic [IW-1:0]     r_stage;
    logic [c_RW-1:0]   r_retry;
    logic [CNT_W-1:0]  r_timer;

    state_t                w_state_nxt;
    logic [IW-1:0]         w_stage_nxt;
    logic [c_RW-1:0]       w_retry_nxt;
    logic [CNT_W-1:0]      w_timer_nxt;
    logic [NUM_STAGES-1:0] w_release_nxt;
    logic [IW-1:0]         w_fail_stage_nxt;
    logic                  w_timeout;

    assign w_timeout = (r_timer == c_TMO_LAST);

    // State/counter registers; outputs are registered from the next-state view
    // so every output lines up with the state it describes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_stage        <= '0;
            r_retry        <= '0;
            r_timer        <= '0;
            crypto_start   <= 1'b0;
            crypto_img_idx <= '0;
            stage_release  <= '0;
            chain_pass     <= 1'b0;
            chain_fail     <= 1'b0;
            fail_stage     <= '0;
            busy           <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_stage        <= w_stage_nxt;
            r_retry        <= w_retry_nxt;
            r_timer        <= w_timer_nxt;
            crypto_start   <= (w_state_nxt == S_ISSUE);
            crypto_img_idx <= w_stage_nxt;
            stage_release  <= w_release_nxt;
            chain_pass     <= (w_state_nxt == S_PASS);
            chain_fail     <= (w_state_nxt == S_FAIL);
            fail_stage     <= w_fail_stage_nxt;
            busy           <= (w_state_nxt == S_ISSUE) || (w_state_nxt == S_WAIT);
        end
    end

    // Next-state logic: tamper outranks engine results, which outrank timeout.
    always_comb begin
        w_state_nxt      = r_state;
        w_stage_nxt      = r_stage;
        w_retry_nxt      = r_retry;
        w_timer_nxt      = r_timer;
        w_release_nxt    = stage_release;
        w_fail_stage_nxt = fail_stage;

        case (r_state)
            S_IDLE: begin
                if (tamper) begin
                    w_state_nxt      = S_FAIL;
                    w_fail_stage_nxt = '0;
                    w_release_nxt    = '0;
                end else if (boot_req) begin
                    w_state_nxt = S_ISSUE;
                    w_stage_nxt = '0;
                    w_retry_nxt = '0;
                end
            end
            S_ISSUE: begin
                // A done seen here belongs to no attempt and is dropped.
                if (tamper) begin
                    w_state_nxt      = S_FAIL;
                    w_fail_stage_nxt = r_stage;
                    w_release_nxt    = '0;
                end else begin
                    w_state_nxt = S_WAIT;
                    w_timer_nxt = '0;
                end
            end
            S_WAIT: begin
                if (r_timer != c_TIMER_MAX) begin
                    w_timer_nxt = r_timer + 1'b1;
                end
                if (tamper) begin
                    w_state_nxt      = S_FAIL;
                    w_fail_stage_nxt = r_stage;
                    w_release_nxt    = '0;
                end else if (crypto_done && crypto_sig_ok) begin
                    w_release_nxt[r_stage] = 1'b1;
                    if (r_stage == c_LAST_STAGE) begin
                        w_state_nxt = S_PASS;
                    end else begin
                        w_stage_nxt = r_stage + 1'b1;
                        w_retry_nxt = '0;
                        w_state_nxt = S_ISSUE;
                    end
                end else if (crypto_done || w_timeout) begin
                    if (r_retry < c_MAX_RETRY) begin
                        w_retry_nxt = r_retry + 1'b1;
                        w_state_nxt = S_ISSUE;
                    end else begin
                        w_state_nxt      = S_FAIL;
                        w_fail_stage_nxt = r_stage;
                        w_release_nxt    = '0;
                    end
                end
            end
            S_PASS: begin
                if (tamper) begin
                    w_state_nxt      = S_FAIL;
                    w_fail_stage_nxt = r_stage;
                    w_release_nxt    = '0;
                end
            end
            S_FAIL: begin
                w_release_nxt = '0;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
